// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing for the multi-cycle Booth multiplier.
//   state_t       : sequencer states {IDLE, RUN, DONE}, 2-bit encoding
//   MULT_WIDTH    : default operand / result width
//   MULT_CNT_W    : default iteration counter width (2**MULT_CNT_W > MULT_WIDTH)
//   MULT_LAST_CNT : counter value at the final Booth step for the default width
//   last_cnt()    : same value for an arbitrary width
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MULT_WIDTH    = 32;
    localparam int MULT_CNT_W    = 6;
    localparam int MULT_LAST_CNT = MULT_WIDTH - 1;

    // Counter value on the edge that performs the last of w Booth steps.
    function automatic int last_cnt(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   acc, q, qm1 : current accumulator, multiplier register and Q(-1) bit
//   a           : multiplicand
//   acc_nxt, q_nxt, qm1_nxt : state after the add/sub and the arithmetic
//                 right shift of {acc, q, qm1}
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             qm1_nxt
);

    // One guard bit: acc - A overflows WIDTH bits when A is the most
    // negative value, but the sum shifted right by one always fits again.
    logic [WIDTH:0] acc_x;
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] sum;

    always_comb begin
        acc_x = {acc[WIDTH-1], acc};
        a_x   = {a[WIDTH-1], a};
        case ({q[0], qm1})
            2'b01:   sum = acc_x + a_x;
            2'b10:   sum = acc_x - a_x;
            default: sum = acc_x;
        endcase
        // Arithmetic shift of {sum, q, qm1}: sum[WIDTH] is the true sign.
        acc_nxt = sum[WIDTH:1];
        q_nxt   = {sum[0], q[WIDTH-1:1]};
        qm1_nxt = q[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: multi-cycle signed radix-2 Booth multiplier.
//   clock        : rising-edge clock
//   resetn       : asynchronous active-low reset, aborts any operation
//   start        : request, sampled only in IDLE
//   multiplicand : signed operand A, captured on an accepted start
//   multiplier   : signed operand B, captured on an accepted start
//   busy         : high in RUN and DONE (pipeline stall request)
//   result_rdy   : one-cycle pulse when result / ovf become valid
//   result       : low WIDTH bits of the signed product (held until next DONE)
//   ovf          : product does not fit in WIDTH signed bits
//   result_hi    : high WIDTH bits of the product, only when the macro
//                  BOOTH_MULT_HI_EN is defined
// Timing: start edge, WIDTH RUN edges, one DONE cycle with result_rdy,
// then IDLE. Start in RUN or DONE is dropped, not queued.
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W   // 2**CNT_W must exceed WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic             ovf
`ifdef BOOTH_MULT_HI_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(last_cnt(WIDTH));

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             qm1_nxt;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .q       (q),
        .qm1     (qm1),
        .a       (a_reg),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .qm1_nxt (qm1_nxt)
    );

    // Product {acc_nxt, q_nxt} fits in WIDTH signed bits only when bits
    // [2W-1:W-1] are all copies of the sign.
    logic [WIDTH:0] top_bits;
    logic           prod_ovf;

    always_comb begin
        top_bits = {acc_nxt, q_nxt[WIDTH-1]};
        prod_ovf = ~((&top_bits) | ~(|top_bits));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            a_reg      <= '0;
            acc        <= '0;
            q          <= '0;
            qm1        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            result_rdy <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
`ifdef BOOTH_MULT_HI_EN
            result_hi  <= '0;
`endif
        end else begin
            result_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= multiplicand;
                        q     <= multiplier;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    qm1 <= qm1_nxt;
                    cnt <= cnt + 1'b1;
                    // Capture straight from the step outputs so the result
                    // is valid in the single DONE cycle.
                    if (cnt == LAST) begin
                        state      <= DONE;
                        result_rdy <= 1'b1;
                        result     <= q_nxt;
                        ovf        <= prod_ovf;
`ifdef BOOTH_MULT_HI_EN
                        result_hi  <= acc_nxt;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Multi-cycle signed multiplier (radix-2 Booth) for the execute stage; companion to the combinational shift unit, consuming the same 32-bit operand buses and writing back via the same result mux.
- Accepts one operation on a start pulse, iterates one Booth step per cycle, presents a 32-bit product plus signed-overflow flag, and holds it until the next start.
- The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  signed operand A; captured on an accepted start.
- multiplier  input  WIDTH  signed operand B; captured on an accepted start.
- busy  output  1  high while an operation is in flight; stall request to the pipeline.
- result_rdy  output  1  one-cycle pulse when result and ovf become valid.
- result  output  WIDTH  low WIDTH bits of the signed product.
- ovf  output  1  signed product does not fit in WIDTH bits.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; busy=0, result_rdy=0, result=0, ovf=0.
  - Internal accumulator, multiplier register, Q(-1) bit and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a clock edge: latch A into the multiplicand register and B into Q; clear the accumulator and Q(-1); counter=0; go to RUN.
  - busy rises in the cycle after that edge.
- RUN, one Booth step per edge:
  - {Q0,Q(-1)}=01: accumulator += A.
  - {Q0,Q(-1)}=10: accumulator -= A.
  - 00 and 11: no change.
  - Then arithmetic-right-shift {acc,Q,Q(-1)} by 1. The add/sub uses WIDTH+1 bits so that the step is correct for A=0x80000000.
  - Counter increments. After WIDTH steps (count==WIDTH-1 at the edge), go to DONE.
- DONE, one cycle:
  - result_rdy=1.
  - result = low WIDTH bits of the 2*WIDTH product.
  - ovf=1 iff product bits [2*WIDTH-1:WIDTH-1] are not all equal.
  - Next edge: go to IDLE.
- Latency: start edge E0, then RUN edges E1..E32, result_rdy high during the cycle after E32, back to IDLE after E33.
- busy=1 in RUN and DONE; busy=0 in IDLE.
- result and ovf are registered and hold their value until the DONE of the next operation. They do not clear at the next start.
- start while busy=1: ignored, with no queueing. Start sampled in the DONE cycle: ignored. Start re-asserted in the IDLE cycle after DONE: accepted, giving back-to-back operation.
- Operands may change after the start edge without affecting the result.
- resetn asserted mid-operation: immediate abort to IDLE, all outputs 0, no result_rdy.

Optional Feature:
- Macro BOOTH_MULT_HI_EN.
- Defined:
  - Adds output port result_hi (WIDTH), the high WIDTH bits of the full 2*WIDTH signed product.
  - result_hi is registered, updated in DONE alongside result, and reset to 0.
- Undefined:
  - No result_hi port; the high half is used only for ovf.
  - Synthesis may trim the accumulator's output register.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - MULT_WIDTH=32 and MULT_CNT_W=6.
  - Localparam for the final count (WIDTH-1).
- One natural sub-module, booth_step:
  - Combinational; inputs acc, Q, Q(-1), A; outputs the next acc, Q, Q(-1).
  - Instantiated once inside booth_multiplier.

Test Plan:
- 3 * 5, start pulse: busy=1 for 33 cycles; result_rdy one cycle after the 32nd step; result=15, ovf=0.
- -7 (0xFFFFFFF9) * 6: result=0xFFFFFFD6 (-42), ovf=0.
- 0x7FFFFFFF * 2: result=0xFFFFFFFE, ovf=1. Also 0x80000000 * 0xFFFFFFFF (-1): result=0x80000000, ovf=1. With BOOTH_MULT_HI_EN, result_hi=0x00000000 for the first and 0x00000000 for the second (+2^31 = 0x00000000_80000000).
- -1 * -1: result=1, ovf=0. 0x80000000 * 1: result=0x80000000, ovf=0.
- Start pulses at cycles 5 and 20 of an op computing 4*4, with different operands on those pulses: result stays 16 and only one result_rdy occurs. A start in the IDLE cycle after DONE is accepted.
- resetn=0 at step 10 of 9*9: busy, result, ovf and result_rdy go 0 asynchronously with no result_rdy. A new 9*9 after release gives 81.
